// File: rtl/uart_cmd_wrapper.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_wrapper
// Function : 8N1 UART front end; pairs received bytes into 16-bit commands
//            and serialises 8-bit response bytes.
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_wrapper #(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        trmt,
    output logic        tx_done
);

    localparam int CNT_W = $clog2(BAUD_DIV + BAUD_DIV / 2 + 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic       {ASM_HIGH, ASM_LOW}                   asm_state_t;
    typedef enum logic       {TX_IDLE, TX_BUSY}                    tx_state_t;

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             byte_rdy_q, byte_rdy_d;
    logic             frame_err;
    logic             start_det;

    asm_state_t       asm_state_q, asm_state_d;
    logic [7:0]       high_q, high_d;
    logic [15:0]      cmd_q, cmd_d;
    logic             cmd_rdy_q, cmd_rdy_d;
    logic             cmd_load;

    tx_state_t        tx_state_q, tx_state_d;
    logic [9:0]       tx_shift_q, tx_shift_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]       tx_bit_q, tx_bit_d;
    logic             tx_done_q, tx_done_d;

    // Synchroniser presets high so reset never looks like a start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign start_det = (rx_state_q == RX_IDLE) && rx_prev_q && !rx_sync_q;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        byte_rdy_d = 1'b0;
        frame_err  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (start_det) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = HALF_M1;
                end
            end
            RX_START: begin
                if (rx_cnt_q == '0) begin
                    if (rx_sync_q) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                        rx_cnt_d   = FULL_M1;
                        rx_bit_d   = 3'd0;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - CNT_ONE;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == '0) begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_cnt_d   = FULL_M1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - CNT_ONE;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == '0) begin
                    rx_state_d = RX_IDLE;
                    byte_rdy_d = rx_sync_q;
                    frame_err  = !rx_sync_q;
                end else begin
                    rx_cnt_d = rx_cnt_q - CNT_ONE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // rx_shift_q holds the completed byte while byte_rdy_q is high
    always_comb begin
        asm_state_d = asm_state_q;
        high_d      = high_q;
        cmd_d       = cmd_q;
        cmd_rdy_d   = cmd_rdy_q;
        cmd_load    = 1'b0;
        if (frame_err) begin
            asm_state_d = ASM_HIGH;
        end else if (byte_rdy_q) begin
            if (asm_state_q == ASM_HIGH) begin
                high_d      = rx_shift_q;
                asm_state_d = ASM_LOW;
            end else begin
                cmd_d       = {high_q, rx_shift_q};
                cmd_load    = 1'b1;
                asm_state_d = ASM_HIGH;
            end
        end
        if (clr_cmd_rdy || (start_det && asm_state_q == ASM_HIGH)) begin
            cmd_rdy_d = 1'b0;
        end
        if (cmd_load) begin
            cmd_rdy_d = 1'b1;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_done_d  = tx_done_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (trmt) begin
                    tx_shift_d = {1'b1, resp, 1'b0};
                    tx_cnt_d   = FULL_M1;
                    tx_bit_d   = 4'd0;
                    tx_done_d  = 1'b0;
                    tx_state_d = TX_BUSY;
                end
            end
            TX_BUSY: begin
                if (tx_cnt_q == '0) begin
                    if (tx_bit_q == 4'd9) begin
                        tx_state_d = TX_IDLE;
                        tx_done_d  = 1'b1;
                    end else begin
                        tx_shift_d = {1'b1, tx_shift_q[9:1]};
                        tx_bit_d   = tx_bit_q + 4'd1;
                        tx_cnt_d   = FULL_M1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - CNT_ONE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= 3'd0;
            rx_shift_q  <= 8'h00;
            byte_rdy_q  <= 1'b0;
            asm_state_q <= ASM_HIGH;
            high_q      <= 8'h00;
            cmd_q       <= 16'h0000;
            cmd_rdy_q   <= 1'b0;
            tx_state_q  <= TX_IDLE;
            tx_shift_q  <= 10'h3FF;
            tx_cnt_q    <= '0;
            tx_bit_q    <= 4'd0;
            tx_done_q   <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            byte_rdy_q  <= byte_rdy_d;
            asm_state_q <= asm_state_d;
            high_q      <= high_d;
            cmd_q       <= cmd_d;
            cmd_rdy_q   <= cmd_rdy_d;
            tx_state_q  <= tx_state_d;
            tx_shift_q  <= tx_shift_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_done_q   <= tx_done_d;
        end
    end

    assign TX      = (tx_state_q == TX_BUSY) ? tx_shift_q[0] : 1'b1;
    assign cmd     = cmd_q;
    assign cmd_rdy = cmd_rdy_q;
    assign tx_done = tx_done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_wrapper.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_wrapper
// Function : Directed self-checking bench for uart_cmd_wrapper (BAUD_DIV=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_wrapper;

    localparam int B = 16;
    // Edge (relative to RX start drive) of the stop-bit sample: 2 sync + 1 + B/2 + 9*B
    localparam int STOP_N = 155;
    localparam logic [9:0] C_FRAME_A5 = 10'b1101001010;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        trmt = 1'b0;
    logic        tx_done;

    int n_compared = 0;
    int n_mismatched = 0;

    uart_cmd_wrapper #(.BAUD_DIV(B)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .trmt        (trmt),
        .tx_done     (tx_done)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode: 0 none, 1 low-byte completion timing, 2 auto-clear on start, 3 no cmd_rdy
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int mode,
                              input logic [15:0] exp_cmd);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int c = 0; c < 10 * B; c++) begin
            RX = fr[c / B];
            @(posedge clk);
            #1;
            if (mode == 1 && c + 1 == STOP_N)     chk_val("rdy_at_stop", cmd_rdy, 0);
            if (mode == 1 && c + 1 == STOP_N + 1) begin
                chk_val("rdy_after_stop", cmd_rdy, 1);
                chk_val("cmd_after_stop", cmd, exp_cmd);
            end
            if (mode == 3 && c + 1 == STOP_N + 1) chk_val("rdy_bad_frame", cmd_rdy, 0);
            if (mode == 2 && c + 1 == 2)          chk_val("rdy_before_start", cmd_rdy, 1);
            if (mode == 2 && c + 1 == 4)          chk_val("rdy_autoclear", cmd_rdy, 0);
        end
        RX = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic send_resp(input logic [7:0] r, input logic [9:0] exp_fr, input logic second);
        resp = r;
        trmt = 1'b1;
        @(posedge clk);
        #1;
        trmt = 1'b0;
        for (int m = 1; m <= 161; m++) begin
            if (m <= 160 && (((m - 1) % B) == 0 || ((m - 1) % B) == B - 1))
                chk_val($sformatf("tx_bit%0d_m%0d", (m - 1) / B, m), TX, exp_fr[(m - 1) / B]);
            if (m == 160) chk_val("tx_done_early", tx_done, 0);
            if (m == 161) chk_val("tx_done", tx_done, 1);
            if (second && m == 40) begin
                resp = 8'h5A;
                trmt = 1'b1;
            end
            if (m == 41) trmt = 1'b0;
            if (m < 161) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] fr;
        #1;
        chk_val("rst_TX", TX, 1);
        chk_val("rst_cmd", cmd, 16'h0000);
        chk_val("rst_cmd_rdy", cmd_rdy, 0);
        chk_val("rst_tx_done", tx_done, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Command assembly and consumption
        send_frame(8'h4B, 1'b1, 0, 16'h0);
        send_frame(8'hF1, 1'b1, 1, 16'h4BF1);
        repeat (10) @(posedge clk);
        #1;
        chk_val("rdy_held", cmd_rdy, 1);
        clr_cmd_rdy = 1'b1;
        @(posedge clk);
        #1;
        clr_cmd_rdy = 1'b0;
        chk_val("rdy_cleared", cmd_rdy, 0);
        chk_val("cmd_held_clr", cmd, 16'h4BF1);

        // Framing error resets the assembler to the high byte
        send_frame(8'h4B, 1'b1, 0, 16'h0);
        send_frame(8'hF1, 1'b0, 3, 16'h0);
        chk_val("cmd_after_bad", cmd, 16'h4BF1);
        send_frame(8'h2A, 1'b1, 0, 16'h0);
        send_frame(8'h55, 1'b1, 1, 16'h2A55);

        // Response transmit with an ignored second trmt
        send_resp(8'hA5, C_FRAME_A5, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk_val("tx_idle_after", TX, 1);

        // Unconsumed cmd_rdy drops when a new high byte starts
        send_frame(8'h77, 1'b1, 2, 16'h0);
        send_frame(8'h88, 1'b1, 1, 16'h7788);

        // Glitch rejection then full duplex
        RX = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        RX = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        fork
            send_resp(8'hA5, C_FRAME_A5, 1'b0);
            begin
                send_frame(8'h12, 1'b1, 0, 16'h0);
                send_frame(8'h34, 1'b1, 1, 16'h1234);
            end
        join

        // Reset during 5th data bit of a low byte and mid TX frame
        send_frame(8'h4B, 1'b1, 0, 16'h0);
        fr = {1'b1, 8'hF1, 1'b0};
        resp = 8'h00;
        trmt = 1'b1;
        for (int c = 0; c < 88; c++) begin
            RX = fr[c / B];
            @(posedge clk);
            #1;
            if (c == 0) trmt = 1'b0;
        end
        chk_val("tx_pre_rst", TX, 0);
        chk_val("cmd_pre_rst", cmd, 16'h1234);
        rst_n = 1'b0;
        #1;
        chk_val("rst2_TX", TX, 1);
        chk_val("rst2_cmd_rdy", cmd_rdy, 0);
        chk_val("rst2_cmd", cmd, 16'h0000);
        chk_val("rst2_tx_done", tx_done, 0);
        RX = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        send_frame(8'h4B, 1'b1, 0, 16'h0);
        send_frame(8'hF1, 1'b1, 1, 16'h4BF1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_cmd_wrapper.md
# uart_cmd_wrapper

Serial front end of the Knight: receives 19200-baud 8N1 bytes from the remote controller on `RX`, assembles each high-byte/low-byte pair into a 16-bit command for the command processor, and serialises the 8-bit response byte (positive acknowledge, move done) back on `TX`. It sits directly upstream of the command processor (`cmd`, `cmd_rdy`, `clr_cmd_rdy`) and downstream of it for responses (`resp`, `trmt`, `tx_done`).

## Interface
- `BAUD_DIV`, default 2604: clocks per bit time (50 MHz / 19200); must be ≥ 8.
- `clk` input 1: system clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `RX` input 1: serial in from remote; asynchronous, idle high.
- `TX` output 1: serial out to remote; idle high.
- `cmd` output 16: last assembled command, `{high_byte, low_byte}`.
- `cmd_rdy` output 1: `cmd` is valid and unconsumed.
- `clr_cmd_rdy` input 1: one-cycle pulse from the command processor consuming `cmd`.
- `resp` input 8: response byte, sampled on `trmt`.
- `trmt` input 1: one-cycle pulse that starts transmission of `resp`.
- `tx_done` output 1: last transmission finished.

## Operation
- Reset values: `TX`=1, `cmd`=16'h0000, `cmd_rdy`=0, `tx_done`=0. The receiver is IDLE and the assembler expects the HIGH byte.
- RX synchroniser: two flops, preset to 1 on reset. All receive logic uses the synchronised signal only.
- Receiver FSM states: IDLE, START, DATA, STOP.
  - IDLE→START on a synchronised 1→0 edge.
  - START waits BAUD_DIV/2 clocks, then re-samples. If the sample is 1 (glitch), the FSM returns to IDLE. Otherwise it moves to DATA.
  - DATA samples 8 bits, LSB first, at BAUD_DIV intervals, then moves to STOP.
  - STOP samples after BAUD_DIV more clocks. A sample of 1 gives a valid byte (a one-cycle internal `byte_rdy`). A sample of 0 is a framing error: the byte is discarded and the assembler is forced back to HIGH. Either way the FSM returns to IDLE.
- Assembler FSM states: HIGH, LOW.
  - HIGH + `byte_rdy`: latch the byte as the high byte and go to LOW.
  - LOW + `byte_rdy`: load `cmd` = {high, byte}, set `cmd_rdy`, and go to HIGH.
- `cmd` changes only on a low-byte load. It holds otherwise, including across `clr_cmd_rdy`.
- `cmd_rdy` clears on `clr_cmd_rdy` or on a start edge detected while the assembler is in HIGH (a new command is beginning). Set has priority over clear in the same cycle.
- Transmitter FSM states: IDLE, BUSY.
  - IDLE + `trmt`: load the 10-bit frame {1, resp, 0}, clear `tx_done`, and go to BUSY.
  - BUSY shifts one bit out every BAUD_DIV clocks, LSB first after the start bit.
  - After the stop bit's full period it returns to IDLE and sets `tx_done`.
- `trmt` while BUSY is ignored. The frame in progress and `resp` capture are unaffected.
- Receiver and transmitter are independent. Full duplex operation is required.
- Asserting `rst_n` mid-frame aborts both directions immediately and restores reset values. A partially received command is lost.

## Timing
- Let t0 be the first clock on which the synchronised RX reads 0. Synchroniser latency is 2 clocks.
- Bit k (0=start, 1..8=data, 9=stop) is sampled at t0 + BAUD_DIV/2 + k·BAUD_DIV. Integer division is used; counters are wide enough for 1.5·BAUD_DIV.
- `cmd_rdy` and the new `cmd` are visible 1 clock after the low byte's stop sample.
- `TX` drives the start bit 1 clock after `trmt`. Each bit lasts exactly BAUD_DIV clocks.
- `tx_done` rises 1 + 10·BAUD_DIV clocks after `trmt`.
- No inter-byte timeout: a lone high byte waits indefinitely in LOW until the next byte arrives or a framing error occurs.

## Test plan
- **Command assembly:** BAUD_DIV=16; drive bytes 0x4B then 0xF1 on RX.
  - Required: `cmd`=16'h4BF1 and `cmd_rdy`=1 exactly 1 clock after the second stop sample.
  - `cmd_rdy` remains high until `clr_cmd_rdy`, then 0 the next clock, with `cmd` still 16'h4BF1.
- **Framing error recovery:** send 0x4B, then 0xF1 with stop bit=0, then 0x2A and 0x55.
  - Required: no `cmd_rdy` after the bad frame.
  - Then `cmd`=16'h2A55 (the bad frame resets assembly to HIGH).
- **Auto-clear on new command:** leave `cmd_rdy`=1 unconsumed, then start a new high byte.
  - Required: `cmd_rdy` drops on the start edge (t0 +1).
- **Response transmit:** pulse `trmt` with `resp`=0xA5.
  - Required: `TX` shows 0,1,0,1,0,0,1,0,1,1, each bit 16 clocks wide.
  - `tx_done`=1 at `trmt`+161 clocks.
  - A second `trmt` with 0x5A at +40 clocks does not alter the frame.
- **Full duplex and glitch rejection:** transmit 0xA5 while receiving 0x12,0x34; insert a 3-clock low RX glitch beforehand.
  - Required: the glitch produces no byte; `cmd`=16'h1234; TX waveform intact.
- **Reset mid-operation:** deassert `rst_n` during the 5th data bit of a low byte and during a TX frame.
  - Required: immediately `TX`=1, `cmd_rdy`=0, `cmd`=0, `tx_done`=0.
  - The next full pair 0x4B,0xF1 yields 16'h4BF1.
